if_fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register, directly upstream of the ID stage.

---
 rtl/if_fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register, imem req/ack handshake, stall and redirect.
// Optional IF_FETCH_CNT_EN adds out_fetch_cnt, a wrapping count of valid IF/ID loads.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_stall,
    input  logic [1:0]  in_ctrl_PCSrc,
    input  logic [31:0] in_branch_PC_addr,
    input  logic [31:0] in_jump_PC_addr,
    input  logic [31:0] in_jr_PC_addr,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    input  logic        in_imem_ack,
    input  logic [31:0] in_imem_rdata,
    output logic [31:0] out_instruct,
    output logic [31:0] out_PC_addr,
    output logic        out_valid
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] out_fetch_cnt
`endif
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        req_q, req_d;
    logic        redirect;
    logic [31:0] tgt_sel;
    logic [31:0] tgt;
    logic [31:0] pc_inc;
    logic        load_vld;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] cnt_q, cnt_d;
`endif

    assign redirect = (in_ctrl_PCSrc != 2'b00) && !in_stall;
    assign pc_inc   = pc_q + 32'd4;

    always_comb begin
        case (in_ctrl_PCSrc)
            2'b01:   tgt_sel = in_branch_PC_addr;
            2'b10:   tgt_sel = in_jump_PC_addr;
            2'b11:   tgt_sel = in_jr_PC_addr;
            default: tgt_sel = pc_inc;
        endcase
    end
    assign tgt = {tgt_sel[31:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcp4_d   = pcp4_q;
        valid_d  = valid_q;
        buf_d    = buf_q;
        buf_pc_d = buf_pc_q;
        tgt_d    = tgt_q;
        load_vld = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (in_imem_ack) begin
                    if (redirect) begin
                        pc_d    = tgt;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else if (!in_stall) begin
                        instr_d  = in_imem_rdata;
                        pcp4_d   = pc_inc;
                        valid_d  = 1'b1;
                        load_vld = 1'b1;
                        pc_d     = pc_inc;
                    end else begin
                        // ID is stalled: park the word so it is neither lost nor refetched
                        buf_d    = in_imem_rdata;
                        buf_pc_d = pc_inc;
                        pc_d     = pc_inc;
                        state_d  = HOLD;
                    end
                end else if (redirect) begin
                    tgt_d   = tgt;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = DRAIN;
                end else if (!in_stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (!in_stall) begin
                    state_d = FETCH;
                    if (redirect) begin
                        pc_d    = tgt;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else begin
                        instr_d  = buf_q;
                        pcp4_d   = buf_pc_q;
                        valid_d  = 1'b1;
                        load_vld = 1'b1;
                    end
                end
            end
            default: begin
                // DRAIN: the in-flight access must finish on its old address
                if (!in_stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
                if (in_imem_ack) begin
                    pc_d    = tgt_q;
                    state_d = FETCH;
                end
            end
        endcase
        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

`ifdef IF_FETCH_CNT_EN
    assign cnt_d = load_vld ? cnt_q + 32'd1 : cnt_q;
`endif

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pcp4_q   <= 32'd0;
            valid_q  <= 1'b0;
            buf_q    <= 32'd0;
            buf_pc_q <= 32'd0;
            tgt_q    <= 32'd0;
            req_q    <= 1'b0;
`ifdef IF_FETCH_CNT_EN
            cnt_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
            buf_q    <= buf_d;
            buf_pc_q <= buf_pc_d;
            tgt_q    <= tgt_d;
            req_q    <= req_d;
`ifdef IF_FETCH_CNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign out_imem_req  = req_q;
    assign out_imem_addr = pc_q;
    assign out_instruct  = instr_q;
    assign out_PC_addr   = pcp4_q;
    assign out_valid     = valid_q;
`ifdef IF_FETCH_CNT_EN
    assign out_fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then randomized stall/redirect/wait traffic,
// checked against a program-order model of the instruction stream ID should receive.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] br_addr, jp_addr, jr_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr, pcp4;
    logic        valid;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fcnt;
`endif

    int wait_mode;
    int wl;
    logic junk_ack;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_pc;
    logic        bubble_exp;
    logic        pend;
    logic [31:0] pend_addr;
    int          consumed;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_stall(stall), .in_ctrl_PCSrc(pcsrc),
        .in_branch_PC_addr(br_addr), .in_jump_PC_addr(jp_addr), .in_jr_PC_addr(jr_addr),
        .out_imem_req(imem_req), .out_imem_addr(imem_addr), .in_imem_ack(imem_ack),
        .in_imem_rdata(imem_rdata), .out_instruct(instr), .out_PC_addr(pcp4), .out_valid(valid)
`ifdef IF_FETCH_CNT_EN
        , .out_fetch_cnt(fcnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0001;
        if (a == 32'h4) return 32'h2009_0002;
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    function automatic int pick();
        if (wait_mode == 0) return 0;
        if (wait_mode == 1) return int'($urandom_range(0, 3));
        return 3;
    endfunction

    // Memory: fixed per-access wait count, combinational ack/rdata
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wl <= pick();
        else if (imem_req && imem_ack)  wl <= pick();
        else if (imem_req && wl > 0)    wl <= wl - 1;
    end
    assign imem_ack   = (imem_req && wl == 0) || junk_ack;
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: model ID consumption at this negedge, then advance to the next negedge.
    task automatic cyc();
        if (pend) chk("addr_hold", imem_addr, pend_addr);
        if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (bubble_exp) begin
            chk("redirect_bubble", {31'd0, valid}, 32'd0);
            bubble_exp = 1'b0;
        end
        if (valid && !stall) begin
            chk("stream_instr", instr, mem_word(exp_pc));
            chk("stream_pc", pcp4, exp_pc + 32'd4);
            consumed++;
            case (pcsrc)
                2'b01:   begin exp_pc = br_addr & ~32'd3; bubble_exp = 1'b1; end
                2'b10:   begin exp_pc = jp_addr & ~32'd3; bubble_exp = 1'b1; end
                2'b11:   begin exp_pc = jr_addr & ~32'd3; bubble_exp = 1'b1; end
                default: exp_pc = exp_pc + 32'd4;
            endcase
        end
        pend      = imem_req && !imem_ack;
        pend_addr = imem_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic       dec_have;
        logic [1:0] dec_src;
        int         idle;
        int         base;
        rst_n = 1'b0; stall = 1'b0; pcsrc = 2'b00;
        br_addr = '0; jp_addr = '0; jr_addr = '0;
        wait_mode = 0; junk_ack = 1'b0;
        exp_pc = 32'h0; bubble_exp = 1'b0; pend = 1'b0; pend_addr = '0; consumed = 0;
        repeat (2) @(negedge clk);

        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pcp4, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
`ifdef IF_FETCH_CNT_EN
        chk("rst_cnt", fcnt, 32'd0);
`endif

        // 1: zero-wait streaming from reset
        rst_n = 1'b1;
        cyc();
        chk("s1_addr0", imem_addr, 32'h0);
        chk("s1_req", {31'd0, imem_req}, 32'd1);
        cyc();
        chk("s1_addr4", imem_addr, 32'h4);
        chk("s1_instr0", instr, 32'h2008_0001);
        chk("s1_pc0", pcp4, 32'h4);
        chk("s1_valid", {31'd0, valid}, 32'd1);
        cyc();
        chk("s1_addr8", imem_addr, 32'h8);
        chk("s1_instr1", instr, 32'h2009_0002);
        chk("s1_pc1", pcp4, 32'h8);
`ifdef IF_FETCH_CNT_EN
        chk("s1_cnt", fcnt, 32'd2);
`endif

        // 2: two-cycle stall while @8 is acked
        stall = 1'b1;
        cyc();
        chk("s2_req_hold", {31'd0, imem_req}, 32'd0);
        chk("s2_instr_hold", instr, 32'h2009_0002);
        cyc();
        chk("s2_req_hold2", {31'd0, imem_req}, 32'd0);
        chk("s2_instr_hold2", instr, 32'h2009_0002);
        stall = 1'b0;
        cyc();
        chk("s2_instr8", instr, mem_word(32'h8));
        chk("s2_pc8", pcp4, 32'hC);
        chk("s2_addrC", imem_addr, 32'hC);

        // 3: branch, zero wait
        pcsrc = 2'b01; br_addr = 32'h40;
        cyc();
        pcsrc = 2'b00;
        chk("s3_addr", imem_addr, 32'h40);
        chk("s3_bubble", {31'd0, valid}, 32'd0);
        cyc();
        chk("s3_instr", instr, mem_word(32'h40));
        chk("s3_pc", pcp4, 32'h44);

        // 4: jump while the access at 0x48 waits 3 cycles
        wait_mode = 2;
        cyc();
        chk("s4_addr48", imem_addr, 32'h48);
        pcsrc = 2'b10; jp_addr = 32'h100;
        cyc();
        pcsrc = 2'b00;
        chk("s4_drain_addr", imem_addr, 32'h48);
        chk("s4_drain_nop", instr, 32'h0);
        cyc();
        chk("s4_drain_addr2", imem_addr, 32'h48);
        cyc();
        chk("s4_drain_ack", {31'd0, imem_ack}, 32'd1);
        chk("s4_drain_valid", {31'd0, valid}, 32'd0);
        cyc();
        chk("s4_addr100", imem_addr, 32'h100);
        chk("s4_nop", {31'd0, valid}, 32'd0);
        wait_mode = 0;
        for (int k = 0; k < 8 && !valid; k++) cyc();
        chk("s4_instr", instr, mem_word(32'h100));
        chk("s4_pc", pcp4, 32'h104);

        // 5: jr with misaligned target, then a branch masked by stall
        pcsrc = 2'b11; jr_addr = 32'h203;
        cyc();
        pcsrc = 2'b00;
        chk("s5_jr_addr", imem_addr, 32'h200);
        cyc();
        chk("s5_jr_instr", instr, mem_word(32'h200));
        pcsrc = 2'b01; br_addr = 32'h80; stall = 1'b1;
        cyc();
        chk("s5_stall_req", {31'd0, imem_req}, 32'd0);
        chk("s5_stall_instr", instr, mem_word(32'h200));
        cyc();
        chk("s5_stall_instr2", instr, mem_word(32'h200));
        stall = 1'b0;
        cyc();
        pcsrc = 2'b00;
        chk("s5_br_addr", imem_addr, 32'h80);

        // PC wrap at the top of the address space
        cyc();
        chk("wrap_pre", instr, mem_word(32'h80));
        pcsrc = 2'b10; jp_addr = 32'hFFFF_FFFC;
        cyc();
        pcsrc = 2'b00;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_instr", instr, mem_word(32'hFFFF_FFFC));
        chk("wrap_pc", pcp4, 32'h0);
        chk("wrap_next", imem_addr, 32'h0);

        // 6: asynchronous reset in the middle of a waited access
        wait_mode = 2;
        cyc();
        chk("s6_pending_addr", imem_addr, 32'h4);
        chk("s6_pending_ack", {31'd0, imem_ack}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_instr", instr, 32'h0);
        chk("s6_rst_pc", pcp4, 32'h0);
        chk("s6_rst_valid", {31'd0, valid}, 32'd0);
        chk("s6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("s6_rst_addr", imem_addr, 32'h0);
`ifdef IF_FETCH_CNT_EN
        chk("s6_rst_cnt", fcnt, 32'd0);
`endif
        wait_mode = 1; junk_ack = 1'b1;
        exp_pc = 32'h0; bubble_exp = 1'b0; pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        junk_ack = 1'b0;
        chk("s6_boot_ack_ignored", {31'd0, valid}, 32'd0);
        chk("s6_refetch_addr", imem_addr, 32'h0);

        // Randomized traffic against the stream model
        dec_have = 1'b0; dec_src = 2'b00; idle = 0; base = consumed;
        for (int i = 0; i < 3000; i++) begin
            if (valid) begin
                if (!dec_have) begin
                    dec_src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    br_addr = $urandom; jp_addr = $urandom; jr_addr = $urandom;
                    dec_have = 1'b1;
                end
                pcsrc = dec_src;
            end else begin
                pcsrc = 2'b00;
                dec_have = 1'b0;
            end
            stall = ($urandom_range(0, 3) == 0);
            if (valid && !stall) begin
                dec_have = 1'b0;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 60) break;
            cyc();
        end
        stall = 1'b0; pcsrc = 2'b00;
        n_cmp++;
        assert (consumed - base >= 300) else begin
            n_bad++;
            $error("FAIL rand_progress: observed %0d delivered expected >= 300", consumed - base);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
